// File: rtl/ps2_receive_pkg.sv
// Shared constants for the PS/2 receiver: FSM state codes, rejection causes,
// frame geometry and a parity helper. Status decoding elsewhere relies on these codes.
package ps2_receive_pkg;

    localparam int PS2_FRAME_LEN = 11;
    localparam int PS2_DATA_BITS = 8;

    localparam logic [2:0] PS2R_IDLE   = 3'd0;
    localparam logic [2:0] PS2R_DATA   = 3'd1;
    localparam logic [2:0] PS2R_PARITY = 3'd2;
    localparam logic [2:0] PS2R_STOP   = 3'd3;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_START   = 3'd1;
    localparam logic [2:0] ERR_PARITY  = 3'd2;
    localparam logic [2:0] ERR_STOP    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad conditioning for one PS/2 line: two-flop synchroniser, stability filter
// and a single-cycle pulse when the filtered value falls.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic filt,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          filt_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts consecutive samples that disagree with the current filtered value;
    // any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= pad;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign filt = filt_q;
    assign fall = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_receive.sv
// PS/2 device-to-host receiver: deframes start/8 data/odd parity/stop and strobes
// valid for good bytes or err with a cause code for rejected frames.
module ps2_receive
    import ps2_receive_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       enable,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [2:0] errCode,
    output logic [2:0] status
);
    localparam logic [16:0] TIMER_LAST = 17'(TIMEOUT_CYC - 1);

    logic c_filt_unused, c_fall;
    logic d_filt, d_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (qzt_clk),
        .rst  (reset),
        .pad  (PS2C),
        .filt (c_filt_unused),
        .fall (c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (qzt_clk),
        .rst  (reset),
        .pad  (PS2D),
        .filt (d_filt),
        .fall (d_fall_unused)
    );

    logic [2:0]  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [16:0] timer_q, timer_d;
    logic        parity_q, parity_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        parity_d   = parity_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        timer_d    = (state_q == PS2R_IDLE) ? 17'd0 : timer_q + 17'd1;

        // Priority: sender owns the bus, then inter-edge timeout, then the edge itself.
        if (!enable) begin
            state_d  = PS2R_IDLE;
            timer_d  = '0;
            bitcnt_d = '0;
        end else if (state_q != PS2R_IDLE && timer_q == TIMER_LAST) begin
            state_d    = PS2R_IDLE;
            timer_d    = '0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (c_fall) begin
            timer_d = '0;
            case (state_q)
                PS2R_IDLE: begin
                    if (!d_filt) begin
                        state_d  = PS2R_DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_START;
                    end
                end
                PS2R_DATA: begin
                    shift_d  = {d_filt, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(PS2_DATA_BITS - 1)) begin
                        state_d = PS2R_PARITY;
                    end
                end
                PS2R_PARITY: begin
                    parity_d = d_filt;
                    state_d  = PS2R_STOP;
                end
                PS2R_STOP: begin
                    state_d = PS2R_IDLE;
                    if (!d_filt) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_STOP;
                    end else if (!odd_parity_ok(shift_q, parity_q)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PARITY;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = PS2R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state_q    <= PS2R_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            timer_q    <= '0;
            parity_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            timer_q    <= timer_d;
            parity_q   <= parity_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign errCode = err_code_q;
    assign status  = state_q;

endmodule

// File: tb/tb_ps2_receive.sv
// Bench for ps2_receive: a bus model drives PS/2 frames, a frame-level reference
// predicts each outcome, strobes are timestamped and compared against it.
module tb_ps2_receive;
    localparam int F     = 8;
    localparam int T     = 300;
    localparam int LAT   = F + 3;
    localparam int HALF  = 20;
    localparam int SETUP = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c, ps2d, enable;
    logic [7:0] data;
    logic       valid, err;
    logic [2:0] err_code, status;

    ps2_receive #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
        .qzt_clk (clk),
        .reset   (rst),
        .PS2C    (ps2c),
        .PS2D    (ps2d),
        .enable  (enable),
        .data    (data),
        .valid   (valid),
        .err     (err),
        .errCode (err_code),
        .status  (status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         is_err;
        logic [7:0] val;
    } ev_t;

    ev_t evq[$];
    int  both_cnt = 0;

    always @(negedge clk) begin
        if (valid && err) both_cnt++;
        if (valid) evq.push_back('{cyc, 1'b0, data});
        if (err)   evq.push_back('{cyc, 1'b1, {5'b0, err_code}});
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int last_fall;

    task automatic send_bit(input logic b);
        ps2d = b;
        tick(SETUP);
        ps2c = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2c = 1'b1;
        tick(HALF - SETUP);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    // Reference state: last good byte and last rejection cause.
    logic [7:0] model_data;
    logic [2:0] model_code;

    task automatic model_frame(input logic [7:0] b, input logic par, input logic stp,
                               output bit is_err, output logic [7:0] val);
        int ones;
        ones = $countones(b) + int'(par);
        if (!stp) begin
            is_err = 1'b1; val = 8'd3;
        end else if (ones % 2 == 0) begin
            is_err = 1'b1; val = 8'd2;
        end else begin
            is_err = 1'b0; val = b;
        end
    endtask

    task automatic expect_one(input string tag, input bit is_err, input logic [7:0] val,
                              input int at);
        ev_t ev;
        check_eq({tag, ".count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            check_eq({tag, ".kind"}, {31'd0, ev.is_err}, {31'd0, is_err});
            check_eq({tag, ".val"},  {24'd0, ev.val}, {24'd0, val});
            check_eq({tag, ".cyc"},  ev.at, at);
        end
        evq.delete();
        if (is_err) model_code = val[2:0];
        else        model_data = val;
        check_eq({tag, ".data"},    {24'd0, data}, {24'd0, model_data});
        check_eq({tag, ".errCode"}, {29'd0, err_code}, {29'd0, model_code});
    endtask

    task automatic expect_none(input string tag);
        check_eq({tag, ".none"}, evq.size(), 0);
        evq.delete();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                             input logic stp);
        bit         is_err;
        logic [7:0] val;
        evq.delete();
        send_bits({stp, par, b, 1'b0}, 11);
        tick(5);
        model_frame(b, par, stp, is_err, val);
        expect_one(tag, is_err, val, last_fall + LAT);
        $display("%s: byte=%02h par=%0d stop=%0d -> %s %02h", tag, b, par, stp,
                 is_err ? "err" : "valid", val);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp, rs;

        ps2c = 1'b1; ps2d = 1'b1; enable = 1'b1; rst = 1'b1;
        model_data = 8'h00; model_code = 3'd0;
        tick(3);
        check_eq("rst.status_in", {29'd0, status}, 32'd0);
        rst = 1'b0;
        tick(3);
        check_eq("rst.data",    {24'd0, data}, 32'd0);
        check_eq("rst.valid",   {31'd0, valid}, 32'd0);
        check_eq("rst.err",     {31'd0, err}, 32'd0);
        check_eq("rst.errCode", {29'd0, err_code}, 32'd0);
        check_eq("rst.status",  {29'd0, status}, 32'd0);
        $display("reset released");

        run_frame("fa_good",   8'hFA, 1'b1, 1'b1);
        run_frame("b2b_00",    8'h00, 1'b1, 1'b1);
        run_frame("b2b_08",    8'h08, 1'b0, 1'b1);
        run_frame("ff_badpar", 8'hFF, 1'b0, 1'b1);
        run_frame("55_stop0",  8'h55, 1'b0, 1'b0);

        // Start bit of 1: a single clock pulse rejected from IDLE.
        send_bit(1'b1);
        tick(5);
        expect_one("badstart", 1'b1, 8'd1, last_fall + LAT);
        $display("badstart: start=1 -> err 1");

        // Clock stops after four data bits.
        send_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 5);
        tick(T + 20);
        expect_one("timeout", 1'b1, 8'd4, last_fall + LAT + T);
        $display("timeout: after 4 data bits -> err 4");
        run_frame("aa_after_to", 8'hAA, 1'b1, 1'b1);

        // Enable drops mid-frame; the rest of the frame is ignored.
        send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 4);
        tick(2);
        check_eq("en.status_data", {29'd0, status}, 32'd1);
        enable = 1'b0;
        tick(2);
        check_eq("en.status_idle", {29'd0, status}, 32'd0);
        for (int i = 4; i < 11; i++) send_bit((i == 10) ? 1'b1 : 1'b0);
        tick(5);
        enable = 1'b1;
        tick(5);
        expect_none("en_abort");
        check_eq("en.status_end", {29'd0, status}, 32'd0);
        $display("enable abort: no strobes");

        // Reset mid-frame while short glitches hit PS2C.
        send_bits({1'b1, 1'b0, 8'h81, 1'b0}, 5);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 ps2c = 1'b0;
            #5 ps2c = 1'b1;
            tick(2);
        end
        rst = 1'b0;
        model_data = 8'h00;
        model_code = 3'd0;
        for (int i = 0; i < 6; i++) begin
            #2 ps2c = 1'b0;
            #5 ps2c = 1'b1;
            tick(F + 2);
        end
        for (int i = 1; i < F; i++) begin
            ps2c = 1'b0;
            tick(i);
            ps2c = 1'b1;
            tick(F + 3);
        end
        tick(20);
        expect_none("rst_glitch");
        check_eq("rg.status",  {29'd0, status}, 32'd0);
        check_eq("rg.data",    {24'd0, data}, {24'd0, model_data});
        check_eq("rg.errCode", {29'd0, err_code}, {29'd0, model_code});
        $display("reset mid-frame + glitches: no strobes");

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom_range(0, 255));
            rp = ~^rb;
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            rs = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rand%0d", n), rb, rp, rs);
        end

        check_eq("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
